urv_dbg_mbx_host: RTL and testbench
===================================

URV_DBG_MBX_HOST -- requirements
Module: urv_dbg_mbx_host

Interface
REQ-001 The module SHALL have parameter g_timeout_cycles, default 1024, meaning WAIT-state cycles before a request is withdrawn (0 = never time out; legal range 0..65535).
REQ-002 The module SHALL have port clk_i  input  1  single clock, all logic rising-edge.
REQ-003 The module SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 The module SHALL have port req_valid_i  input  1  host request word valid.
REQ-005 The module SHALL have port req_ready_o  output  1  block can accept a request.
REQ-006 The module SHALL have port req_data_i  input  31  request payload.
REQ-007 The module SHALL have port rsp_valid_o  output  1  response valid.
REQ-008 The module SHALL have port rsp_ready_i  input  1  host accepts response.
REQ-009 The module SHALL have port rsp_data_o  output  31  response payload from CPU.
REQ-010 The module SHALL have port rsp_timeout_o  output  1  response is a timeout, not CPU data; qualified by rsp_valid_o.
REQ-011 The module SHALL have port abort_i  input  1  host cancels an outstanding request.
REQ-012 The module SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-013 The module SHALL have port mbx_write_o  output  1  write strobe into the CPU debug mailbox.
REQ-014 The module SHALL have port mbx_data_o  output  32  word written into the CPU debug mailbox.
REQ-015 The module SHALL have port mbx_data_i  input  32  current CPU debug mailbox contents.

Function
REQ-016 Mailbox word format SHALL be bit 31 = pending flag (1 = host request not yet consumed), bits 30:0 = payload; the CPU consumes a request by writing the mailbox CSR with bit 31 = 0 and its reply in 30:0.
REQ-017 FSM states SHALL be IDLE, WRITE, SETTLE, WAIT, RESP; reset state IDLE.
REQ-018 IDLE: req_ready_o=1; on req_valid_i at edge N, latch req_data_i and go WRITE; req_ready_o=0 in all other states.
REQ-019 WRITE (cycle N+1): mbx_write_o=1, mbx_data_o={1'b1, latched payload} for exactly one cycle, then SETTLE.
REQ-020 SETTLE (cycle N+2): no strobe, mbx_data_i ignored (mailbox register update latency), then WAIT; first WAIT sample at cycle N+3.
REQ-021 WAIT: timeout counter (16 bit) cleared on WAIT entry, increments each WAIT cycle; when mbx_data_i[31]=0, latch mbx_data_i[30:0] to rsp_data_o, rsp_timeout_o=0, go RESP.
REQ-022 WAIT timeout: when g_timeout_cycles!=0 and counter reaches g_timeout_cycles-1 with bit 31 still set, drive one-cycle mbx_write_o=1 with mbx_data_o=32'h0 (withdraw), rsp_data_o=0, rsp_timeout_o=1, go RESP.
REQ-023 WAIT abort: abort_i=1 with bit 31 still set SHALL drive one-cycle withdraw write (32'h0) and go IDLE with no response; abort_i in any other state SHALL be ignored.
REQ-024 Priority in the same WAIT cycle SHALL be: CPU reply (bit 31=0) > abort_i > timeout.
REQ-025 RESP: rsp_valid_o=1 with rsp_data_o/rsp_timeout_o stable until the cycle rsp_ready_i=1; then IDLE next cycle; rsp_valid_o=0 in all other states.
REQ-026 mbx_write_o SHALL be high only in WRITE and on withdraw cycles; mbx_data_o SHALL be 32'h0 whenever mbx_write_o=0.
REQ-027 A new request SHALL NOT be accepted in the cycle the response handshake completes (one IDLE cycle minimum between transactions).

Reset
REQ-028 Asserting rst_i in any state, including mid-WAIT, SHALL immediately force IDLE, counter=0, latched payload=0, req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_timeout_o=0, busy_o=0, mbx_write_o=0, mbx_data_o=0; no withdraw write is issued on reset.

Verification
REQ-029 Basic: req_data_i=31'h1234 at edge N -> mbx_write_o=1, mbx_data_o=32'h80001234 at N+1; model sets mbx_data_i=32'h00005678 at N+5 -> rsp_valid_o=1, rsp_data_o=31'h5678, rsp_timeout_o=0 from N+6.
REQ-030 Timeout: g_timeout_cycles=8, mbx_data_i held 32'h80000001 -> after 8 WAIT cycles one withdraw strobe with mbx_data_o=0, then rsp_valid_o=1, rsp_timeout_o=1, rsp_data_o=0.
REQ-031 Abort: abort_i pulsed in 3rd WAIT cycle -> one withdraw strobe (32'h0), busy_o=0 next cycle, rsp_valid_o never asserts.
REQ-032 Collision: reply bit 31=0, abort_i=1 and counter at limit in the same cycle -> normal response, no withdraw strobe.
REQ-033 Backpressure: rsp_ready_i held 0 for 10 cycles in RESP -> rsp_valid_o and rsp_data_o stable, req_ready_o=0; accepted on rsp_ready_i=1, req_ready_o=1 one cycle later.
REQ-034 Reset mid-WAIT: rst_i asserted asynchronously between edges -> all outputs at REQ-028 values before the next clock edge, no mailbox strobe.

Source files
------------

// File: rtl/urv_dbg_mbx_host.sv
// Host-side debug mailbox bridge: posts a request word into the CPU debug mailbox,
// waits for the CPU to consume it, and returns the reply, a timeout, or nothing on abort.
//
// state  | meaning
// IDLE   | ready for a host request
// WRITE  | strobe {pending, payload} into the mailbox
// SETTLE | mailbox register update latency, mbx_data_i not yet valid
// WAIT   | poll pending flag; reply, abort or timeout
// RESP   | hold response until the host accepts it
module urv_dbg_mbx_host #(
    parameter int unsigned g_timeout_cycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [30:0] req_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [30:0] rsp_data_o,
    output logic        rsp_timeout_o,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        mbx_write_o,
    output logic [31:0] mbx_data_o,
    input  logic [31:0] mbx_data_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SETTLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam bit          TO_EN   = (g_timeout_cycles != 0);
    localparam logic [15:0] TO_LAST = 16'(g_timeout_cycles - 1);

    state_t      state, state_nxt;
    logic [30:0] payload_q;
    logic [15:0] cnt_q;
    logic [30:0] rsp_data_q;
    logic        rsp_tmo_q;
    logic        pending;
    logic        timeout_hit;

    assign pending     = mbx_data_i[31];
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        busy_o      = 1'b1;
        mbx_write_o = 1'b0;
        mbx_data_o  = 32'h0;
        rsp_valid_o = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mbx_write_o = 1'b1;
                mbx_data_o  = {1'b1, payload_q};
                state_nxt   = S_SETTLE;
            end
            S_SETTLE: state_nxt = S_WAIT;
            S_WAIT: begin
                // A CPU reply wins over abort, abort wins over timeout.
                if (!pending) begin
                    state_nxt = S_RESP;
                end else if (abort_i || timeout_hit) begin
                    mbx_write_o = 1'b1;
                    state_nxt   = abort_i ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            payload_q  <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_tmo_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE:   if (req_valid_i) payload_q <= req_data_i;
                S_SETTLE: cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (!pending) begin
                        rsp_data_q <= mbx_data_i[30:0];
                        rsp_tmo_q  <= 1'b0;
                    end else if (!abort_i && timeout_hit) begin
                        rsp_data_q <= '0;
                        rsp_tmo_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data_o    = rsp_data_q;
    assign rsp_timeout_o = rsp_tmo_q;

endmodule

// File: tb/tb_urv_dbg_mbx_host.sv
// Randomized bench for urv_dbg_mbx_host: each transaction's timeline is derived from
// its reply/abort/timeout cycle numbers and compared against the DUT every cycle.
module tb_urv_dbg_mbx_host;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [30:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [30:0] rsp_data;
    logic        rsp_timeout;
    logic        abort;
    logic        busy;
    logic        mbx_write;
    logic [31:0] mbx_data_out;
    logic [31:0] mbx_data_in;

    always #5 clk = ~clk;

    urv_dbg_mbx_host #(.g_timeout_cycles(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_timeout_o(rsp_timeout), .abort_i(abort), .busy_o(busy),
        .mbx_write_o(mbx_write), .mbx_data_o(mbx_data_out), .mbx_data_i(mbx_data_in)
    );

    int total  = 0;
    int passed = 0;

    logic        exp_en = 1'b0;
    logic        exp_rdy, exp_busy, exp_wr, exp_vld, exp_tmo;
    logic [31:0] exp_wdata;
    logic [30:0] exp_rdata;

    logic [31:0] cap_wdata;
    logic [30:0] cap_rdata;
    logic        cap_tmo;
    int          cap_wd, cap_vld;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (exp_en && !rst) begin
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("mbx_write", 32'(mbx_write), 32'(exp_wr));
            chk("mbx_data", mbx_data_out, exp_wdata);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
            if (exp_vld) begin
                chk("rsp_data", 32'(rsp_data), 32'(exp_rdata));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_tmo));
            end
        end
    end

    task automatic set_exp(input logic rdy, input logic bsy, input logic wr,
                           input logic [31:0] wd, input logic vld,
                           input logic [30:0] rd, input logic tmo);
        exp_rdy = rdy; exp_busy = bsy; exp_wr = wr; exp_wdata = wd;
        exp_vld = vld; exp_rdata = rd; exp_tmo = tmo;
    endtask

    task automatic step();
        @(negedge clk);
        if (mbx_write && mbx_data_out == 32'h0) cap_wd++;
        if (mbx_write && mbx_data_out[31]) cap_wdata = mbx_data_out;
        if (rsp_valid) begin
            cap_vld++;
            cap_rdata = rsp_data;
            cap_tmo   = rsp_timeout;
        end
        @(posedge clk);
        #1;
    endtask

    // reply_at / abort_at: 1-based WAIT cycle index, 0 = never.
    task automatic run_txn(input logic [30:0] pl, input int reply_at, input int abort_at,
                           input int bp, input logic [30:0] rdat);
        int          wend;
        int          kind;
        logic [30:0] erd;
        cap_wd = 0; cap_vld = 0; cap_wdata = '0; cap_rdata = '0; cap_tmo = 1'b0;
        wend = 1 << 30;
        if (reply_at > 0) wend = reply_at;
        if (abort_at > 0 && abort_at < wend) wend = abort_at;
        if (TO > 0 && TO < wend) wend = TO;
        kind = (reply_at == wend) ? 0 : (abort_at == wend) ? 1 : 2;

        req_valid = 1'b1; req_data = pl;
        abort = 1'($urandom_range(1, 0)); mbx_data_in = $urandom;
        set_exp(1, 0, 0, 32'h0, 0, '0, 0);
        step();
        req_valid = 1'b0; req_data = 31'($urandom);
        abort = 1'($urandom_range(1, 0)); mbx_data_in = $urandom;
        set_exp(0, 1, 1, {1'b1, pl}, 0, '0, 0);
        step();
        // Settle cycle: a cleared pending flag must be ignored here.
        abort = 1'($urandom_range(1, 0)); mbx_data_in = {1'b0, 31'($urandom)};
        set_exp(0, 1, 0, 32'h0, 0, '0, 0);
        step();
        for (int w = 1; w <= wend; w++) begin
            abort = (w == abort_at);
            mbx_data_in = (reply_at > 0 && w >= reply_at) ? {1'b0, rdat} : {1'b1, pl};
            set_exp(0, 1, (w == wend) && (kind != 0), 32'h0, 0, '0, 0);
            step();
        end
        abort = 1'b0;
        if (kind == 1) begin
            set_exp(1, 0, 0, 32'h0, 0, '0, 0);
            step();
            return;
        end
        erd = (kind == 0) ? rdat : 31'h0;
        for (int i = 0; i <= bp; i++) begin
            rsp_ready = (i == bp);
            req_valid = (i == bp);
            req_data  = 31'($urandom);
            abort     = 1'($urandom_range(1, 0));
            mbx_data_in = $urandom;
            set_exp(0, 1, 0, 32'h0, 1, erd, kind == 2);
            step();
        end
        rsp_ready = 1'b0; req_valid = 1'b0; abort = 1'b0;
        set_exp(1, 0, 0, 32'h0, 0, '0, 0);
        step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mbx_write"}, 32'(mbx_write), 32'd0);
        chk({tag, "_mbx_data"}, mbx_data_out, 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_data = '0; rsp_ready = 1'b0;
        abort = 1'b0; mbx_data_in = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_en = 1'b1;

        run_txn(31'h1234, 3, 0, 0, 31'h5678);
        chk("basic_wdata", cap_wdata, 32'h80001234);
        chk("basic_rdata", 32'(cap_rdata), 32'h5678);
        chk("basic_tmo", 32'(cap_tmo), 32'd0);
        chk("basic_withdraws", 32'(cap_wd), 32'd0);
        chk("basic_rsp_cycles", 32'(cap_vld), 32'd1);

        run_txn(31'h1, 0, 0, 2, 31'h7fff_0000);
        chk("timeout_withdraws", 32'(cap_wd), 32'd1);
        chk("timeout_flag", 32'(cap_tmo), 32'd1);
        chk("timeout_rdata", 32'(cap_rdata), 32'd0);
        chk("timeout_rsp_cycles", 32'(cap_vld), 32'd3);

        run_txn(31'h0abc, 0, 3, 0, 31'h1);
        chk("abort_withdraws", 32'(cap_wd), 32'd1);
        chk("abort_rsp_cycles", 32'(cap_vld), 32'd0);

        run_txn(31'h0def, TO, TO, 0, 31'h2aaa);
        chk("collision_withdraws", 32'(cap_wd), 32'd0);
        chk("collision_rdata", 32'(cap_rdata), 32'h2aaa);
        chk("collision_tmo", 32'(cap_tmo), 32'd0);

        run_txn(31'h5555, 2, 0, 10, 31'h1357);
        chk("bp_rsp_cycles", 32'(cap_vld), 32'd11);
        chk("bp_rdata", 32'(cap_rdata), 32'h1357);

        for (int n = 0; n < 40; n++) begin
            run_txn(31'($urandom),
                    ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(12, 1)),
                    ($urandom_range(9, 0) < 3) ? int'($urandom_range(12, 1)) : 0,
                    int'($urandom_range(4, 0)),
                    31'($urandom));
        end

        // Reset mid-WAIT: outputs must clear before the next clock edge.
        run_txn(31'h1234, 1, 0, 0, 31'h5678);
        exp_en = 1'b0;
        req_valid = 1'b1; req_data = 31'h4321; mbx_data_in = 32'h0;
        step();
        req_valid = 1'b0;
        mbx_data_in = {1'b1, 31'h4321};
        repeat (3) step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        chk("rst_no_strobe", 32'(mbx_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("post_rst");
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
